// File: rtl/arb_pkg.sv
// Shared types and helpers for the round-robin arbiter.
package arb_pkg;

  typedef enum logic {
    ARB_IDLE  = 1'b0,
    ARB_GRANT = 1'b1
  } arb_state_t;

  // Never returns zero, so a grant index always has at least one bit.
  function automatic int idx_width(input int num_req);
    return (num_req <= 2) ? 1 : $clog2(num_req);
  endfunction

endpackage

// File: rtl/rr_priority_encoder.sv
// Combinational round-robin search: first set request at or above ptr, modulo NUM_REQ.
module rr_priority_encoder #(
  parameter int NUM_REQ   = 4,
  parameter int IDX_WIDTH = 2
) (
  input  logic [NUM_REQ-1:0]   req,
  input  logic [IDX_WIDTH-1:0] ptr,
  output logic                 found,
  output logic [IDX_WIDTH-1:0] idx
);

  logic [NUM_REQ-1:0] rotated;
  int                 offset;
  int                 unrotated;

  // Rotate so ptr lands at bit 0, take the lowest set bit, then rotate the answer back.
  always_comb begin
    rotated   = '0;
    offset    = 0;
    unrotated = 0;
    for (int i = 0; i < NUM_REQ; i++) begin
      rotated[i] = req[(i + int'(ptr)) % NUM_REQ];
    end
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (rotated[i]) offset = i;
    end
    unrotated = (offset + int'(ptr)) % NUM_REQ;
    found     = |rotated;
    idx       = IDX_WIDTH'(unrotated);
  end

endmodule

// File: rtl/round_robin_arbiter.sv
// Round-robin arbiter: one grant held until release_i, priority rotating past each holder.
// Define ARB_ONEHOT_OUT_EN to add a registered one-hot copy of the grant (grant_onehot).
module round_robin_arbiter
  import arb_pkg::*;
#(
  parameter int NUM_REQ   = 4,
  parameter int IDX_WIDTH = idx_width(NUM_REQ)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_REQ-1:0]   req,
  input  logic                 release_i,
`ifdef ARB_ONEHOT_OUT_EN
  output logic [NUM_REQ-1:0]   grant_onehot,
`endif
  output logic                 grant_valid,
  output logic [IDX_WIDTH-1:0] grant_idx
);

  arb_state_t           state_q, state_d;
  logic [IDX_WIDTH-1:0] ptr_q, ptr_d;
  logic [IDX_WIDTH-1:0] idx_q, idx_d;
  logic [IDX_WIDTH-1:0] rel_ptr;
  logic [IDX_WIDTH-1:0] search_ptr;
  logic                 enc_found;
  logic [IDX_WIDTH-1:0] enc_idx;

  // A release moves priority past the holder so the same search serves back-to-back grants.
  assign rel_ptr    = (idx_q == IDX_WIDTH'(NUM_REQ - 1)) ? '0 : idx_q + 1'b1;
  assign search_ptr = (state_q == ARB_GRANT && release_i) ? rel_ptr : ptr_q;

  rr_priority_encoder #(
    .NUM_REQ  (NUM_REQ),
    .IDX_WIDTH(IDX_WIDTH)
  ) u_enc (
    .req  (req),
    .ptr  (search_ptr),
    .found(enc_found),
    .idx  (enc_idx)
  );

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    idx_d   = idx_q;
    case (state_q)
      ARB_IDLE: begin
        if (enc_found) begin
          state_d = ARB_GRANT;
          idx_d   = enc_idx;
        end
      end
      ARB_GRANT: begin
        if (release_i) begin
          ptr_d = rel_ptr;
          if (enc_found) idx_d = enc_idx;
          else           state_d = ARB_IDLE;
        end
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ARB_IDLE;
      ptr_q   <= '0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      idx_q   <= idx_d;
    end
  end

  assign grant_valid = (state_q == ARB_GRANT);
  assign grant_idx   = idx_q;

`ifdef ARB_ONEHOT_OUT_EN
  logic [NUM_REQ-1:0] onehot_d;
  logic [NUM_REQ-1:0] onehot_q;

  // Decoded from next-state values so it lines up with grant_valid/grant_idx.
  always_comb begin
    onehot_d = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      onehot_d[i] = (state_d == ARB_GRANT) && (idx_d == IDX_WIDTH'(i));
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) onehot_q <= '0;
    else     onehot_q <= onehot_d;
  end

  assign grant_onehot = onehot_q;
`endif

endmodule

// File: tb/tb_round_robin_arbiter.sv
// Directed bench for round_robin_arbiter with NUM_REQ=4; build with ARB_ONEHOT_OUT_EN to cover grant_onehot.
module tb_round_robin_arbiter;

  logic       clk;
  logic       rst;
  logic [3:0] req;
  logic       release_i;
  logic       grant_valid;
  logic [1:0] grant_idx;
`ifdef ARB_ONEHOT_OUT_EN
  logic [3:0] grant_onehot;
`endif

  int checks;
  int errors;

  typedef struct {
    logic [3:0] req;
    logic       rel;
    logic       exp_valid;
    logic [1:0] exp_idx;
    string      name;
  } vec_t;

  localparam int NUM_VECS = 18;
  vec_t vecs [NUM_VECS];

  round_robin_arbiter #(.NUM_REQ(4)) dut (
    .clk         (clk),
    .rst         (rst),
    .req         (req),
    .release_i   (release_i),
`ifdef ARB_ONEHOT_OUT_EN
    .grant_onehot(grant_onehot),
`endif
    .grant_valid (grant_valid),
    .grant_idx   (grant_idx)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic exp_valid, input logic [1:0] exp_idx);
`ifdef ARB_ONEHOT_OUT_EN
    logic [3:0] exp_onehot;
`endif
    checks++;
    if (grant_valid !== exp_valid) begin
      errors++;
      $display("[TB] FAIL %s grant_valid: got %b expected %b", name, grant_valid, exp_valid);
    end
    checks++;
    if (grant_idx !== exp_idx) begin
      errors++;
      $display("[TB] FAIL %s grant_idx: got %0d expected %0d", name, grant_idx, exp_idx);
    end
`ifdef ARB_ONEHOT_OUT_EN
    exp_onehot = exp_valid ? (4'b0001 << exp_idx) : 4'b0000;
    checks++;
    if (grant_onehot !== exp_onehot) begin
      errors++;
      $display("[TB] FAIL %s grant_onehot: got %b expected %b", name, grant_onehot, exp_onehot);
    end
`endif
  endtask

  // Drive inputs away from the rising edge, then sample just after it.
  task automatic applyStimulus(input logic [3:0] r, input logic rel);
    @(negedge clk);
    req       = r;
    release_i = rel;
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Rotation, wrap at 3->0, then hold with req dropped, release in IDLE.
    vecs[0]  = '{4'b1111, 1'b0, 1'b1, 2'd0, "rot_first"};
    vecs[1]  = '{4'b1111, 1'b1, 1'b1, 2'd1, "rot_1"};
    vecs[2]  = '{4'b1111, 1'b1, 1'b1, 2'd2, "rot_2"};
    vecs[3]  = '{4'b1111, 1'b1, 1'b1, 2'd3, "rot_3"};
    vecs[4]  = '{4'b1111, 1'b1, 1'b1, 2'd0, "rot_wrap"};
    vecs[5]  = '{4'b0010, 1'b1, 1'b1, 2'd1, "hold_grant1"};
    vecs[6]  = '{4'b0000, 1'b0, 1'b1, 2'd1, "hold_noreq_a"};
    vecs[7]  = '{4'b0000, 1'b0, 1'b1, 2'd1, "hold_noreq_b"};
    vecs[8]  = '{4'b0000, 1'b1, 1'b0, 2'd1, "release_to_idle"};
    vecs[9]  = '{4'b0000, 1'b1, 1'b0, 2'd1, "idle_release"};
    // ptr is now 2: sole requester 1 found by wrapping, then re-granted on each release.
    vecs[10] = '{4'b0010, 1'b0, 1'b1, 2'd1, "sole_first"};
    vecs[11] = '{4'b0010, 1'b1, 1'b1, 2'd1, "sole_regrant_a"};
    vecs[12] = '{4'b0010, 1'b1, 1'b1, 2'd1, "sole_regrant_b"};
    // Holder 2 released with ptr=3 and req=0101: skip 3, wrap to 0, then 2.
    vecs[13] = '{4'b0100, 1'b1, 1'b1, 2'd2, "grant2"};
    vecs[14] = '{4'b0101, 1'b1, 1'b1, 2'd0, "skip_wrap_0"};
    vecs[15] = '{4'b0101, 1'b1, 1'b1, 2'd2, "skip_to_2"};
    vecs[16] = '{4'b0000, 1'b1, 1'b0, 2'd2, "final_release"};
    vecs[17] = '{4'b0000, 1'b0, 1'b0, 2'd2, "idle_stays"};

    checks    = 0;
    errors    = 0;
    rst       = 1'b1;
    req       = 4'b0000;
    release_i = 1'b0;

    #12;
    checkOutput("reset_state", 1'b0, 2'd0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < NUM_VECS; i++) begin
      applyStimulus(vecs[i].req, vecs[i].rel);
      checkOutput(vecs[i].name, vecs[i].exp_valid, vecs[i].exp_idx);
    end

    // Reset mid-grant clears outputs without an edge; ptr returns to 0 afterwards.
    applyStimulus(4'b0100, 1'b0);
    checkOutput("pre_reset_grant2", 1'b1, 2'd2);
    #2;
    rst = 1'b1;
    #1;
    checkOutput("reset_async", 1'b0, 2'd0);
    req = 4'b1000;
    @(posedge clk);
    #1;
    checkOutput("reset_held", 1'b0, 2'd0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    checkOutput("post_reset_grant3", 1'b1, 2'd3);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/round_robin_arbiter.md
ROUND_ROBIN_ARBITER -- requirements
Module: round_robin_arbiter

Interface
REQ-001 The module SHALL have parameter NUM_REQ, default 4, giving the number of requesters (legal range 2..64).
REQ-002 The module SHALL have parameter IDX_WIDTH, default $clog2(NUM_REQ), giving the width of the binary grant index.
REQ-003 The module SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-004 The module SHALL have port rst, input, 1, the reset, which is asynchronous and active-high.
REQ-005 The module SHALL have port req, input, NUM_REQ, the request vector, where bit i set means requester i wants the resource.
REQ-006 The module SHALL have port release_i, input, 1, the current grant holder finishing its use of the resource.
REQ-007 The module SHALL have port grant_valid, output, 1, asserted while a grant is held.
REQ-008 The module SHALL have port grant_idx, output, IDX_WIDTH, the binary index of the holder, which feeds one_hot_decoder.binary_in downstream.

Function
REQ-009 The block SHALL be a two-state FSM: IDLE (no grant) and GRANT (grant held).
REQ-010 In IDLE with req != 0, the FSM SHALL move to GRANT on the next edge, registering grant_idx as the first set req bit at or above ptr, searching upward modulo NUM_REQ; grant_valid rises one cycle after req is sampled.
REQ-011 In IDLE with req == 0, the FSM SHALL stay in IDLE, with grant_valid=0 and grant_idx unchanged.
REQ-012 In GRANT without release_i, grant_valid and grant_idx SHALL hold, even if req[grant_idx] deasserts.
REQ-013 In GRANT with release_i=1, ptr SHALL become (grant_idx+1) mod NUM_REQ, with wrap from NUM_REQ-1 to 0.
REQ-014 On the same release_i edge, if req != 0, the block SHALL re-arbitrate from the new ptr and stay in GRANT with the new grant_idx, giving back-to-back grants with no idle bubble.
REQ-015 On the same release_i edge, if req == 0, the FSM SHALL return to IDLE.
REQ-016 A sole requester that is released SHALL be re-granted immediately if it is still requesting.
REQ-017 release_i SHALL be ignored in IDLE.
REQ-018 Request bits SHALL be masked to NUM_REQ bits; when NUM_REQ is not a power of two, grant_idx SHALL never exceed NUM_REQ-1.
REQ-019 Fairness: with all requesters continuously active, grants SHALL rotate 0,1,...,NUM_REQ-1,0 with one grant per release.

Reset
REQ-020 While rst=1, the block SHALL force state=IDLE, ptr=0, grant_valid=0 and grant_idx=0, without waiting for a clock edge.
REQ-021 Reset asserted during GRANT SHALL drop grant_valid immediately and discard the holder.
REQ-022 After rst deasserts, the first edge SHALL evaluate req per REQ-010.

Configuration
REQ-023 The macro ARB_ONEHOT_OUT_EN SHALL control an additional output port, grant_onehot, NUM_REQ wide.
REQ-024 With ARB_ONEHOT_OUT_EN defined, grant_onehot SHALL be registered and SHALL equal 1<<grant_idx when grant_valid=1, and all-zero otherwise, including during reset.
REQ-025 With ARB_ONEHOT_OUT_EN undefined, the grant_onehot port and its logic SHALL be absent, and all other behaviour SHALL be identical.

Structure
REQ-026 The package arb_pkg SHALL hold the FSM state enum (ARB_IDLE, ARB_GRANT) and a function computing the index width from the requester count.
REQ-027 The search SHALL be done by one sub-module, rr_priority_encoder: a combinational block with inputs req and ptr and outputs found and idx, using a rotate-then-priority-encode-then-unrotate scheme.
REQ-028 All registers SHALL reside in round_robin_arbiter.

Verification
REQ-029 Reset: a bench SHALL assert rst mid-GRANT with grant_idx=2 -> grant_valid=0 and grant_idx=0 before the next edge; after release of reset, req=4'b1000 -> grant_idx=3 one cycle later.
REQ-030 Rotation: a bench SHALL drive req=4'b1111 and pulse release_i each cycle -> grant_idx sequence 0,1,2,3,0 with grant_valid held at 1 throughout.
REQ-031 Skip and wrap: a bench SHALL drive req=4'b0101 with ptr=3 after releasing holder 2 -> grant_idx=0, then 2 on the next release.
REQ-032 Hold: a bench SHALL grant index 1, then drop req[1] without release_i -> grant_idx stays 1 and grant_valid stays 1 until release_i; with req=0 at release -> grant_valid=0 next cycle.
REQ-033 Sole requester and IDLE release: a bench SHALL drive req=4'b0010 and release_i each cycle -> grant_idx=1 continuously; release_i pulsed in IDLE -> no state change.
REQ-034 Macro: a bench built with ARB_ONEHOT_OUT_EN defined SHALL see grant_onehot=4'b0100 while grant_idx=2, and 4'b0000 in IDLE.
